// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset vector and the layout of a
// fetched instruction entry as it travels from fetch to decode.
package core_pkg;

    // Architectural register / address width.
    localparam int unsigned XLEN = 32;

    // Byte address the core starts fetching from after reset.
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // Canonical NOP (addi x0, x0, 0), used by downstream stages as a bubble.
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    // One fetch queue entry: the PC travels in the upper half, the word below.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = 2 * XLEN;

    // Force a byte address onto a 32-bit word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // True when a byte address is not on a word boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage : core_pkg

// File: rtl/fetch_fifo.sv
// Small synchronous in-order queue for fetched words. Pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
// The head is read combinationally from registered storage; when the queue
// is empty the output holds the last popped entry.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] hold_q,   hold_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] head;
    logic             do_push;
    logic             do_pop;

    // Occupancy flags derived from the wrap bit and the index bits.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // Head of queue, or the last popped entry while empty.
    always_comb begin
        head   = mem_q[rd_ptr_q[AW-1:0]];
        data_o = empty_o ? hold_q : head;
    end

    // Next-state: flush beats everything; a push into a full queue is only
    // legal when the head is leaving in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        mem_d    = mem_q;
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                hold_d   = head;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Pointer and held-output registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // Entry storage; contents are only meaningful behind valid pointers.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the instruction memory
// address, and queues each returned word with its PC for decode. A branch
// redirect from EX restarts fetch at the (word-aligned) target and drops
// everything already buffered.
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned     XLEN       = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = core_pkg::RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            misaligned_o
);

    localparam int unsigned ENTRY_W = 2 * XLEN;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic               misaligned_q, misaligned_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshake and queue control. Redirect suppresses both sides so that
    // nothing fetched from the wrong path survives the flush.
    always_comb begin
        instr_valid_o = !fifo_empty;
        pop           = instr_valid_o && instr_ready_i;
        push          = !redirect_i && (!fifo_full || pop);
        wr_entry      = {pc_q, imem_data_i};
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop && !redirect_i),
        .flush_i (redirect_i),
        .data_i  (wr_entry),
        .data_o  (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Decode-side outputs come straight from registered queue state.
    always_comb begin
        pc_o         = rd_entry[ENTRY_W-1:XLEN];
        instr_o      = rd_entry[XLEN-1:0];
        imem_addr_o  = pc_q;
        misaligned_o = misaligned_q;
    end

    // Next fetch PC: redirect target, sequential advance on push, else stall.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        if (redirect_i) begin
            pc_d         = {redirect_pc_i[XLEN-1:2], 2'b00};
            misaligned_d = |redirect_pc_i[1:0];
        end else if (push) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // Fetch PC and misalignment pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instruction memory is modelled as
// mem[i] = i, i.e. the word returned for byte address A is A >> 2.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        misaligned_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    assign imem_data_i = imem_addr_o >> 2;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .misaligned_o  (misaligned_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Hold reset across one edge, release 1 ns after it.
    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc_exp);
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
        chk({tag, "_pc"}, pc_o, pc_exp);
        chk({tag, "_instr"}, instr_o, pc_exp >> 2);
    endtask

    initial begin
        rst_ni        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
        #12;
        // Reset state
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_mis", {31'd0, misaligned_o}, 32'd0);

        // Test 1: streaming with ready held high
        instr_ready_i = 1'b1;
        do_reset();
        chk("t1_c0_addr", imem_addr_o, 32'h0);
        chk("t1_c0_valid", {31'd0, instr_valid_o}, 32'd0);
        step();
        chk("t1_c1_addr", imem_addr_o, 32'h4);
        chk_head("t1_c1", 32'h0);
        step();
        chk("t1_c2_addr", imem_addr_o, 32'h8);
        chk_head("t1_c2", 32'h4);
        step();
        chk("t1_c3_addr", imem_addr_o, 32'hC);
        chk_head("t1_c3", 32'h8);

        // Test 2: decode stalls for 4 cycles, queue fills and PC stalls
        instr_ready_i = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        chk("t2_stall_addr", imem_addr_o, 32'h8);
        chk_head("t2_stall_head", 32'h0);
        instr_ready_i = 1'b1;
        step();
        chk_head("t2_o1", 32'h4);
        chk("t2_o1_addr", imem_addr_o, 32'hC);
        step();
        chk_head("t2_o2", 32'h8);
        step();
        chk_head("t2_o3", 32'hC);

        // Test 3: redirect while full with ready=1; the pop is discarded
        instr_ready_i = 1'b0;
        do_reset();
        step();
        step();
        chk("t3_full_addr", imem_addr_o, 32'h8);
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h18;
        step();
        redirect_i = 1'b0;
        chk("t3_r1_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t3_r1_addr", imem_addr_o, 32'h18);
        chk("t3_r1_mis", {31'd0, misaligned_o}, 32'd0);
        step();
        chk_head("t3_r2", 32'h18);
        chk("t3_r2_addr", imem_addr_o, 32'h1C);

        // Test 4: misaligned redirect target
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h1A;
        step();
        redirect_i = 1'b0;
        chk("t4_r1_addr", imem_addr_o, 32'h18);
        chk("t4_r1_mis", {31'd0, misaligned_o}, 32'd1);
        chk("t4_r1_valid", {31'd0, instr_valid_o}, 32'd0);
        step();
        chk("t4_r2_mis", {31'd0, misaligned_o}, 32'd0);
        chk_head("t4_r2", 32'h18);

        // Test 5: PC wrap at the top of the address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        step();
        redirect_i = 1'b0;
        chk("t5_r1_addr", imem_addr_o, 32'hFFFF_FFF8);
        step();
        chk_head("t5_w0", 32'hFFFF_FFF8);
        step();
        chk_head("t5_w1", 32'hFFFF_FFFC);
        step();
        chk_head("t5_w2", 32'h0000_0000);

        // Back-to-back redirects: the later target wins
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_pc_i = 32'h80;
        step();
        redirect_i = 1'b0;
        chk("b2b_addr", imem_addr_o, 32'h80);
        chk("b2b_valid", {31'd0, instr_valid_o}, 32'd0);
        step();
        chk_head("b2b_first", 32'h80);

        // Test 6: asynchronous reset while the queue is full
        instr_ready_i = 1'b0;
        step();
        step();
        chk("t6_pre_valid", {31'd0, instr_valid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t6_rst_addr", imem_addr_o, 32'h0);
        chk("t6_rst_pc", pc_o, 32'h0);
        instr_ready_i = 1'b1;
        step();
        rst_ni = 1'b1;
        chk("t6_c0_valid", {31'd0, instr_valid_o}, 32'd0);
        step();
        chk("t6_c1_addr", imem_addr_o, 32'h4);
        chk_head("t6_c1", 32'h0);
        step();
        chk_head("t6_c2", 32'h4);
        step();
        chk_head("t6_c3", 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
